asic_output_classifier: RTL and testbench
=========================================

ASIC_OUTPUT_CLASSIFIER -- requirements
Module: asic_output_classifier

Interface
REQ-001 The block SHALL expose parameter NUM_CH, default 4, giving the number of XADC aux channels scanned (legal range 2..16).
REQ-002 The block SHALL expose parameter AVG_LOG2, default 2, where 2^AVG_LOG2 is the number of scan rounds averaged per decision.
REQ-003 The block SHALL expose parameter BASE_ADDR, default 7'h10, giving the DRP address of channel 0; channel k is read at BASE_ADDR+k.
REQ-004 The block SHALL expose parameter TIMEOUT, default 255, giving the maximum number of clk cycles to wait for DRDY.
REQ-005 Ports SHALL be: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-006 Ports SHALL be: enable  in  1  run scanning; clear_err  in  1  clears timeout_err.
REQ-007 Ports SHALL be: DADDR  out  7  DRP address; DEN  out  1  DRP enable pulse; DWE  out  1  tied 0; DI  out  16  tied 0.
REQ-008 Ports SHALL be: DO  in  16  DRP read data; DRDY  in  1  DRP data valid; EOS  in  1  XADC end-of-sequence pulse.
REQ-009 Ports SHALL be: winner  out  $clog2(NUM_CH)  argmax channel; winner_valid  out  1  one-cycle decision strobe.
REQ-010 Ports SHALL be: measured  out  NUM_CH*12  averaged 12-bit codes, channel k at bits [12k+11:12k]; timeout_err  out  1  sticky.

Function
REQ-011 The FSM SHALL have states IDLE, WAIT_EOS, REQ, WAIT_DRDY, ROUND_DONE, ARGMAX and PUBLISH.
REQ-012 IDLE SHALL go to WAIT_EOS when enable=1; WAIT_EOS SHALL go to IDLE when enable=0 and SHALL otherwise go to REQ with channel index 0 on EOS=1.
REQ-013 REQ SHALL last exactly one cycle, drive DEN=1 and DADDR=BASE_ADDR+index, then go to WAIT_DRDY; DEN SHALL be 0 in every other state.
REQ-014 In WAIT_DRDY, on DRDY=1 the block SHALL add DO[15:4] into acc[index]; it SHALL then go to ROUND_DONE if index=NUM_CH-1, otherwise increment index and go to REQ.
REQ-015 Accumulators SHALL be 12+AVG_LOG2 bits wide and SHALL never overflow.
REQ-016 In WAIT_DRDY, when the wait counter reaches TIMEOUT without DRDY, the block SHALL set timeout_err, restore all acc[] to their values at the start of the round, and go to WAIT_EOS without counting the round.
REQ-017 If DRDY arrives in the same cycle the wait counter reaches TIMEOUT, DRDY SHALL win and no timeout SHALL be recorded.
REQ-018 DRDY SHALL be ignored in every state except WAIT_DRDY.
REQ-019 ROUND_DONE SHALL increment the round counter; it SHALL go to ARGMAX when the count reaches 2^AVG_LOG2 and to WAIT_EOS otherwise.
REQ-020 ARGMAX SHALL compare one channel per cycle for NUM_CH cycles using strict greater-than, so ties resolve to the lowest index.
REQ-021 PUBLISH SHALL register winner and measured[k]=acc[k]>>AVG_LOG2 and pulse winner_valid for exactly one cycle.
REQ-022 PUBLISH SHALL clear all acc[] and the round counter, then go to WAIT_EOS.
REQ-023 winner_valid SHALL be high in cycle N+NUM_CH+2, where cycle N is the one in which the final DRDY is sampled.
REQ-024 winner and measured SHALL hold their values between PUBLISH events.
REQ-025 Deasserting enable outside WAIT_EOS SHALL let the current round finish; deasserting it in WAIT_EOS SHALL discard partial accumulation (acc[] and round counter cleared).
REQ-026 If clear_err=1 and a timeout occur in the same cycle, the set SHALL win.

Reset
REQ-027 On rst=1 at a clk edge, the FSM SHALL enter IDLE and index, round counter, wait counter and acc[] SHALL be cleared.
REQ-028 On reset, DEN, DADDR, winner, winner_valid, measured and timeout_err SHALL all be 0.
REQ-029 Reset SHALL take priority over every other event, including a reset during WAIT_DRDY; no winner_valid SHALL follow a reset.

Verification (NUM_CH=4, AVG_LOG2=2, TIMEOUT=255)
REQ-030 Reset: assert rst for 2 cycles -> all outputs 0 and DEN remains 0 while enable=0.
REQ-031 Constant inputs: DO per channel 0x1000/0x8000/0x4000/0x2000 for 4 rounds -> exactly one winner_valid, winner=1, measured = 0x100/0x800/0x400/0x200, and the strobe lands 6 cycles after the last DRDY.
REQ-032 Tie: channels 0 and 2 both 0x7FF0, others 0x0100 -> winner=0.
REQ-033 Averaging: channel 3 returns 0x0010, 0x0020, 0x0030, 0x0040 across the 4 rounds -> measured ch3 = 0x002.
REQ-034 Timeout: withhold DRDY for channel 2 in round 2 -> timeout_err=1 at wait cycle 255, the round is discarded, and the decision still uses 4 complete rounds; clear_err=1 -> timeout_err=0.
REQ-035 Reset mid-transaction: rst asserted in WAIT_DRDY -> next cycle FSM is IDLE, DEN=0, and a late DRDY has no effect.

Source files
------------

// File: rtl/asic_output_classifier.sv
// asic_output_classifier
// Scans NUM_CH XADC aux channels over the DRP after each end-of-sequence pulse,
// averages 2^AVG_LOG2 complete rounds per channel, then publishes the averaged
// codes and the index of the largest one. A DRP read that never completes
// discards the whole round and raises a sticky timeout flag.
module asic_output_classifier #(
    parameter int         NUM_CH    = 4,
    parameter int         AVG_LOG2  = 2,
    parameter logic [6:0] BASE_ADDR = 7'h10,
    parameter int         TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear_err,
    output logic [6:0]                DADDR,
    output logic                      DEN,
    output logic                      DWE,
    output logic [15:0]               DI,
    input  logic [15:0]               DO,
    input  logic                      DRDY,
    input  logic                      EOS,
    output logic [$clog2(NUM_CH)-1:0] winner,
    output logic                      winner_valid,
    output logic [NUM_CH*12-1:0]      measured,
    output logic                      timeout_err
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int RND_W  = AVG_LOG2 + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [RND_W-1:0]  LAST_RND = RND_W'((1 << AVG_LOG2) - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EOS,
        REQ,
        WAIT_DRDY,
        ROUND_DONE,
        ARGMAX,
        PUBLISH
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  index_reg;
    logic [RND_W-1:0]  round_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [ACC_W-1:0]  acc_reg  [NUM_CH];
    logic [ACC_W-1:0]  snap_reg [NUM_CH];   // acc_reg as it stood when the round began
    logic [11:0]       meas_reg [NUM_CH];
    logic [ACC_W-1:0]  best_val_reg;
    logic [IDX_W-1:0]  best_idx_reg;

    logic              at_last_idx;
    logic              drdy_hit;
    logic              timeout_hit;
    logic              discard;
    logic              argmax_done;
    logic [ACC_W-1:0]  cand_val;
    logic              cand_better;
    logic [IDX_W-1:0]  final_idx;

    assign at_last_idx = (index_reg == LAST_IDX);
    assign drdy_hit    = (state_reg == WAIT_DRDY) && DRDY;
    // DRDY arriving on the final wait cycle wins over the timeout
    assign timeout_hit = (state_reg == WAIT_DRDY) && !DRDY && (wait_cnt_reg == WAIT_MAX);
    assign discard     = (state_reg == WAIT_EOS) && !enable;
    assign argmax_done = (state_reg == ARGMAX) && at_last_idx;

    // Strict greater-than keeps the earliest channel on ties
    assign cand_val    = acc_reg[index_reg];
    assign cand_better = (cand_val > best_val_reg);
    assign final_idx   = cand_better ? index_reg : best_idx_reg;

    assign DWE = 1'b0;
    assign DI  = '0;

    // Next-state logic and DRP request outputs
    always_comb begin
        state_next = state_reg;
        DEN        = 1'b0;
        DADDR      = '0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = WAIT_EOS;
            end
            WAIT_EOS: begin
                if (!enable)  state_next = IDLE;
                else if (EOS) state_next = REQ;
            end
            REQ: begin
                DEN        = 1'b1;
                DADDR      = BASE_ADDR + 7'(index_reg);
                state_next = WAIT_DRDY;
            end
            WAIT_DRDY: begin
                if (DRDY)             state_next = at_last_idx ? ROUND_DONE : REQ;
                else if (timeout_hit) state_next = WAIT_EOS;
            end
            ROUND_DONE: begin
                state_next = (round_cnt_reg == LAST_RND) ? ARGMAX : WAIT_EOS;
            end
            ARGMAX: begin
                if (at_last_idx) state_next = PUBLISH;
            end
            PUBLISH: begin
                state_next = WAIT_EOS;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, sequencing counters, argmax tracker and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            round_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            best_val_reg  <= '0;
            best_idx_reg  <= '0;
            winner        <= '0;
            winner_valid  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            winner_valid <= 1'b0;
            case (state_reg)
                WAIT_EOS: begin
                    index_reg <= '0;
                    if (!enable) round_cnt_reg <= '0;
                end
                REQ: begin
                    wait_cnt_reg <= '0;
                end
                WAIT_DRDY: begin
                    if (DRDY) begin
                        if (!at_last_idx) index_reg <= index_reg + 1'b1;
                    end else if (!timeout_hit) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ROUND_DONE: begin
                    round_cnt_reg <= round_cnt_reg + 1'b1;
                    index_reg     <= '0;
                    best_val_reg  <= '0;
                    best_idx_reg  <= '0;
                end
                ARGMAX: begin
                    if (cand_better) begin
                        best_val_reg <= cand_val;
                        best_idx_reg <= index_reg;
                    end
                    if (at_last_idx) begin
                        winner       <= final_idx;
                        winner_valid <= 1'b1;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                    end
                end
                PUBLISH: begin
                    round_cnt_reg <= '0;
                end
                default: ;
            endcase
            if (timeout_hit)    timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Per-channel accumulator with round-start snapshot for timeout rollback
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_reg[gi]  <= '0;
                snap_reg[gi] <= '0;
            end else if (discard || (state_reg == PUBLISH)) begin
                acc_reg[gi]  <= '0;
                snap_reg[gi] <= '0;
            end else if (timeout_hit) begin
                acc_reg[gi] <= snap_reg[gi];
            end else if (drdy_hit && (index_reg == IDX_W'(gi))) begin
                acc_reg[gi] <= acc_reg[gi] + ACC_W'(DO[15:4]);
            end else if (state_reg == ROUND_DONE) begin
                snap_reg[gi] <= acc_reg[gi];
            end
        end

        // Averaged code captured alongside the winner
        always_ff @(posedge clk) begin
            if (rst) begin
                meas_reg[gi] <= '0;
            end else if (argmax_done) begin
                meas_reg[gi] <= acc_reg[gi][AVG_LOG2 +: 12];
            end
        end

        assign measured[12*gi +: 12] = meas_reg[gi];
    end

endmodule

// File: tb/tb_asic_output_classifier.sv
// Bench for asic_output_classifier: a DRP responder model answers reads with
// per-round table values, a reference model averages complete rounds and
// queues expected decisions, and a monitor checks each winner_valid strobe.
module tb_asic_output_classifier;

    localparam int         NUM_CH   = 4;
    localparam int         AVG_LOG2 = 2;
    localparam int         TIMEOUT  = 255;
    localparam logic [6:0] BASE     = 7'h10;
    localparam int         ROUNDS   = 1 << AVG_LOG2;
    localparam int         W_W      = $clog2(NUM_CH);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   enable = 1'b0;
    logic                   clear_err = 1'b0;
    logic [6:0]             DADDR;
    logic                   DEN;
    logic                   DWE;
    logic [15:0]            DI;
    logic [15:0]            DO = '0;
    logic                   DRDY = 1'b0;
    logic                   EOS = 1'b0;
    logic [W_W-1:0]         winner;
    logic                   winner_valid;
    logic [NUM_CH*12-1:0]   measured;
    logic                   timeout_err;

    asic_output_classifier #(
        .NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
        .DO(DO), .DRDY(DRDY), .EOS(EOS),
        .winner(winner), .winner_valid(winner_valid),
        .measured(measured), .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W_W-1:0]       w;
        logic [NUM_CH*12-1:0] m;
    } exp_t;

    exp_t                 exp_q[$];
    logic [15:0]          data_tbl [NUM_CH];
    int                   sum [NUM_CH];
    int                   nrounds = 0;
    logic [W_W-1:0]       last_w = '0;
    logic [NUM_CH*12-1:0] last_m = '0;

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) sum[ch] = 0;
        nrounds = 0;
    endtask

    // Called once per fully answered round; every ROUNDS rounds yields a decision
    task automatic model_round();
        exp_t e;
        int   best;
        int   avg;
        for (int ch = 0; ch < NUM_CH; ch++) sum[ch] += int'(data_tbl[ch]) / 16;
        nrounds++;
        if (nrounds == ROUNDS) begin
            best = -1;
            e.w  = '0;
            e.m  = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                avg = sum[ch] / ROUNDS;
                e.m[ch*12 +: 12] = 12'(avg);
                if (avg > best) begin
                    best = avg;
                    e.w  = W_W'(ch);
                end
            end
            exp_q.push_back(e);
            model_reset();
        end
    endtask

    // ---------------- DRP responder ----------------
    int drop_ch = -1;
    bit drop_arm = 1'b0;
    bit hung = 1'b0;
    bit noise_en = 1'b0;
    bit inject_late = 1'b0;
    int resp_count = 0;
    int last_drdy_cyc = 0;
    int drop_cyc = 0;

    initial begin
        bit pend;
        int pend_ch;
        int pend_lat;
        int ch;
        pend = 1'b0;
        pend_ch = 0;
        pend_lat = 0;
        forever begin
            @(negedge clk);
            DRDY = 1'b0;
            DO   = 16'($urandom);
            if (inject_late) begin
                DRDY = 1'b1;
                DO   = 16'hFFF0;
                inject_late = 1'b0;
            end else if (pend) begin
                if (pend_lat == 0) begin
                    DRDY = 1'b1;
                    DO   = data_tbl[pend_ch];
                    last_drdy_cyc = cyc;
                    resp_count++;
                    pend = 1'b0;
                end else begin
                    pend_lat--;
                end
            end else if (DEN) begin
                ch = int'(DADDR - BASE);
                if (drop_arm && ch == drop_ch) begin
                    hung     = 1'b1;
                    drop_arm = 1'b0;
                    drop_cyc = cyc;
                end else begin
                    pend     = 1'b1;
                    pend_ch  = ch;
                    pend_lat = $urandom_range(0, 2);
                end
            end else if (noise_en && !hung && $urandom_range(0, 5) == 0) begin
                DRDY = 1'b1;   // stray DRDY while no read is outstanding
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (winner_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual winner=%0d required=no strobe (cycle %0d)", winner, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("winner", 64'(winner), 64'(e.w));
                    chk("measured", 64'(measured), 64'(e.m));
                    chk("strobe_latency", 64'(cyc - last_drdy_cyc), 64'(NUM_CH + 2));
                    last_w = e.w;
                    last_m = e.m;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_tbl();
        for (int ch = 0; ch < NUM_CH; ch++) data_tbl[ch] = 16'($urandom);
    endtask

    // One scan round; drop >= 0 withholds DRDY for that channel
    task automatic do_round(input int drop);
        int base;
        bit ok;
        base     = resp_count;
        drop_ch  = drop;
        drop_arm = (drop >= 0);
        EOS = 1'b1;
        @(negedge clk);
        EOS = 1'b0;
        ok = 1'b0;
        if (drop < 0) begin
            for (int i = 0; i < 400; i++) begin
                if (resp_count == base + NUM_CH) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("round_complete", 64'(ok), 64'd1);
            if (ok) model_round();
            tick(NUM_CH + 6);
        end else begin
            for (int i = 0; i < TIMEOUT + 100; i++) begin
                @(negedge clk);
                if (timeout_err === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("timeout_seen", 64'(ok), 64'd1);
            // REQ cycle, then wait counts 0..TIMEOUT, flag visible the cycle after
            if (ok) chk("timeout_latency", 64'(cyc - drop_cyc), 64'(TIMEOUT + 2));
            hung = 1'b0;
            tick(4);
        end
    endtask

    initial begin
        int den_seen;

        model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) data_tbl[ch] = '0;

        // Reset for two clock edges with enable low
        tick(3);
        rst = 1'b0;
        chk("rst_den", 64'(DEN), 64'd0);
        chk("rst_daddr", 64'(DADDR), 64'd0);
        chk("rst_winner", 64'(winner), 64'd0);
        chk("rst_winner_valid", 64'(winner_valid), 64'd0);
        chk("rst_measured", 64'(measured), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("dwe_di_tied", 64'({DWE, DI}), 64'd0);
        den_seen = 0;
        EOS = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            EOS = 1'b0;
            if (DEN !== 1'b0) den_seen++;
        end
        chk("den_idle_while_disabled", 64'(den_seen), 64'd0);

        enable = 1'b1;
        tick(2);

        // Constant per-channel inputs
        data_tbl[0] = 16'h1000; data_tbl[1] = 16'h8000;
        data_tbl[2] = 16'h4000; data_tbl[3] = 16'h2000;
        for (int r = 0; r < ROUNDS; r++) do_round(-1);
        chk("const_winner", 64'(last_w), 64'd1);
        chk("const_measured", 64'(last_m), 64'h200400800100);

        // Tie between channels 0 and 2
        data_tbl[0] = 16'h7FF0; data_tbl[1] = 16'h0100;
        data_tbl[2] = 16'h7FF0; data_tbl[3] = 16'h0100;
        for (int r = 0; r < ROUNDS; r++) do_round(-1);
        chk("tie_winner", 64'(last_w), 64'd0);

        // Averaging on channel 3
        for (int r = 0; r < ROUNDS; r++) begin
            rand_tbl();
            data_tbl[3] = 16'(16 * (r + 1));
            do_round(-1);
        end
        chk("avg_ch3", 64'(last_m[47:36]), 64'd2);

        // Timeout on channel 2 in round 2; five rounds give four complete ones
        for (int r = 0; r < ROUNDS + 1; r++) begin
            rand_tbl();
            do_round(r == 2 ? 2 : -1);
        end
        chk("timeout_sticky", 64'(timeout_err), 64'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_err", 64'(timeout_err), 64'd0);

        // Dropping enable in WAIT_EOS discards partial accumulation
        for (int r = 0; r < 2; r++) begin
            rand_tbl();
            do_round(-1);
        end
        enable = 1'b0;
        tick(3);
        model_reset();
        enable = 1'b1;
        tick(2);
        for (int r = 0; r < ROUNDS; r++) begin
            rand_tbl();
            do_round(-1);
        end

        // Reset while waiting for DRDY, followed by a late DRDY
        rand_tbl();
        do_round(-1);
        rand_tbl();
        drop_ch  = 1;
        drop_arm = 1'b1;
        EOS = 1'b1;
        @(negedge clk);
        EOS = 1'b0;
        tick(12);
        chk("read_outstanding", 64'(hung), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_den", 64'(DEN), 64'd0);
        chk("midrst_winner", 64'(winner), 64'd0);
        chk("midrst_measured", 64'(measured), 64'd0);
        chk("midrst_winner_valid", 64'(winner_valid), 64'd0);
        model_reset();
        last_w = '0;
        last_m = '0;
        inject_late = 1'b1;
        tick(3);
        hung     = 1'b0;
        drop_arm = 1'b0;
        tick(NUM_CH + 8);
        chk("late_drdy_no_err", 64'(timeout_err), 64'd0);
        for (int r = 0; r < ROUNDS; r++) begin
            rand_tbl();
            do_round(-1);
        end

        // Random decisions with stray DRDY pulses
        noise_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < ROUNDS; r++) begin
                rand_tbl();
                do_round(-1);
            end
        end
        noise_en = 1'b0;

        // Outputs hold between decisions
        tick(20);
        chk("hold_winner", 64'(winner), 64'(last_w));
        chk("hold_measured", 64'(measured), 64'(last_m));
        chk("all_decisions_seen", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=time limit reached required=completion");
        $fatal(1, "watchdog");
    end

endmodule
